// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among Nreq byte sources. A round-robin arbiter
// picks one requester while idle, then drives the transmitter through its
// start / end-of-transmission handshake. A watchdog abandons a transfer whose
// end-of-transmission pulse never arrives.
//
// Ports
//   clk_i     in   1             system clock, all state on the rising edge
//   rst_i     in   1             asynchronous, active-low reset
//   req_i     in   Nreq          req_i[k]=1: requester k offers a byte
//   data_i    in   Nreq*Nbits    requester k byte = data_i[k*Nbits +: Nbits]
//   gnt_o     out  Nreq          one-hot 1-cycle pulse: requester byte taken
//   owner_o   out  $clog2(Nreq)  index of current / last granted requester
//   busy_o    out  1             high while loading or waiting for the frame
//   tx_stt_o  out  1             1-cycle start pulse to the transmitter
//   tx_din_o  out  Nbits         byte to transmitter, stable until next load
//   tx_eot_i  in   1             end-of-transmission pulse from transmitter
//   err_o     out  1             1-cycle pulse: watchdog abort
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int Nreq       = 4,
  parameter int Nbits      = 8,
  parameter int TimeoutCyc = 16384
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [Nreq-1:0]         req_i,
  input  logic [Nreq*Nbits-1:0]   data_i,
  output logic [Nreq-1:0]         gnt_o,
  output logic [$clog2(Nreq)-1:0] owner_o,
  output logic                    busy_o,
  output logic                    tx_stt_o,
  output logic [Nbits-1:0]        tx_din_o,
  input  logic                    tx_eot_i,
  output logic                    err_o
);

  localparam int OW = $clog2(Nreq);
  localparam int CW = ($clog2(TimeoutCyc) < 1) ? 1 : $clog2(TimeoutCyc);

  localparam logic [CW-1:0] CNT_LAST   = CW'(TimeoutCyc - 1);
  localparam logic [OW-1:0] OWNER_LAST = OW'(Nreq - 1);
  localparam logic [OW:0]   NREQ_W     = (OW+1)'(Nreq);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic [Nbits-1:0]  din_q, din_d;
  logic [Nreq-1:0]   gnt_q, gnt_d;
  logic              stt_q, stt_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Per-requester byte slices, so the winner's byte is a plain array lookup.
  logic [Nbits-1:0] slice [Nreq];

  for (genvar gi = 0; gi < Nreq; gi++) begin : g_slice
    assign slice[gi] = data_i[gi*Nbits +: Nbits];
  end

  // Round-robin search: walk offsets from the highest down so the last hit
  // written is the one closest to rr_q, i.e. the first in rr_q, rr_q+1, ...
  logic [OW-1:0] winner;
  logic          any_req;
  logic [OW:0]   cand_idx;

  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    cand_idx = '0;
    for (int i = Nreq - 1; i >= 0; i--) begin
      cand_idx = {1'b0, rr_q} + (OW+1)'(i);
      if (cand_idx >= NREQ_W) begin
        cand_idx = cand_idx - NREQ_W;
      end
      if (req_i[cand_idx[OW-1:0]]) begin
        winner  = cand_idx[OW-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Pointer for the next arbitration: the requester after the one just served.
  logic [OW-1:0] owner_next;
  assign owner_next = (owner_q == OWNER_LAST) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    din_d   = din_q;
    gnt_d   = '0;
    stt_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (any_req) begin
          // Registered outputs: the start/grant pulse is set on the edge that
          // enters LOAD, so it is visible exactly during the LOAD cycle.
          owner_d = winner;
          din_d   = slice[winner];
          gnt_d   = {{(Nreq-1){1'b0}}, 1'b1} << winner;
          stt_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        busy_d = 1'b1;
        if (tx_eot_i) begin
          // End-of-transmission wins over a coincident terminal count.
          busy_d  = 1'b0;
          rr_d    = owner_next;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          rr_d    = owner_next;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      din_q   <= '0;
      gnt_q   <= '0;
      stt_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      din_q   <= din_d;
      gnt_q   <= gnt_d;
      stt_q   <= stt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign owner_o  = owner_q;
  assign busy_o   = busy_q;
  assign tx_stt_o = stt_q;
  assign tx_din_o = din_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. u_dut uses the default watchdog length
// for the arbitration/handshake scenarios; u_to uses an 8-cycle watchdog for
// the timeout scenarios. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic [3:0]  req, gnt;
  logic [31:0] data;
  logic [1:0]  owner;
  logic        busy, stt, eot, err;
  logic [7:0]  din;

  logic [3:0]  req_t, gnt_t;
  logic [31:0] data_t;
  logic [1:0]  owner_t;
  logic        busy_t, stt_t, eot_t, err_t;
  logic [7:0]  din_t;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.Nreq(4), .Nbits(8), .TimeoutCyc(16384)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .req_i    (req),
    .data_i   (data),
    .gnt_o    (gnt),
    .owner_o  (owner),
    .busy_o   (busy),
    .tx_stt_o (stt),
    .tx_din_o (din),
    .tx_eot_i (eot),
    .err_o    (err)
  );

  uart_tx_arbiter #(.Nreq(4), .Nbits(8), .TimeoutCyc(8)) u_to (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .req_i    (req_t),
    .data_i   (data_t),
    .gnt_o    (gnt_t),
    .owner_o  (owner_t),
    .busy_o   (busy_t),
    .tx_stt_o (stt_t),
    .tx_din_o (din_t),
    .tx_eot_i (eot_t),
    .err_o    (err_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer on u_dut: arbitration edge, LOAD, WAIT, eot sampled
  // eot_dly edges after the edge that raised tx_stt_o.
  task automatic transfer(input int idx, input logic [7:0] byte_exp,
                          input int eot_dly, input string tag);
    tick();
    $display("xfer %s: owner=%0d byte=%02h gnt=%b", tag, owner, din, gnt);
    chk({tag, "_stt"},   32'(stt),   32'd1);
    chk({tag, "_gnt"},   32'(gnt),   32'd1 << idx);
    chk({tag, "_owner"}, 32'(owner), 32'(idx));
    chk({tag, "_din"},   32'(din),   32'(byte_exp));
    chk({tag, "_busy"},  32'(busy),  32'd1);
    tick();
    chk({tag, "_stt_off"}, 32'(stt),  32'd0);
    chk({tag, "_gnt_off"}, 32'(gnt),  32'd0);
    chk({tag, "_wait"},    32'(busy), 32'd1);
    repeat (eot_dly - 2) tick();
    eot = 1'b1;
    tick();
    eot = 1'b0;
    chk({tag, "_idle"},  32'(busy), 32'd0);
    chk({tag, "_noerr"}, 32'(err),  32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    data   = '0;
    eot    = 1'b0;
    req_t  = '0;
    data_t = '0;
    eot_t  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_stt",   32'(stt),   32'd0);
    chk("rst_din",   32'(din),   32'd0);
    chk("rst_err",   32'(err),   32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_stt",  32'(stt),  32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Fairness: all requesting, order 0,1,2,3,0
    req  = 4'b1111;
    data = 32'h4433_2211;
    transfer(0, 8'h11, 5, "fair0");
    transfer(1, 8'h22, 5, "fair1");
    transfer(2, 8'h33, 5, "fair2");
    transfer(3, 8'h44, 5, "fair3");
    transfer(0, 8'h11, 5, "fair4");
    req = 4'b0000;

    // Single requester 2, req/data changes during the transfer are ignored
    req  = 4'b0100;
    data = 32'h11A5_3322;
    tick();
    $display("xfer single: owner=%0d byte=%02h gnt=%b", owner, din, gnt);
    chk("single_stt",   32'(stt),   32'd1);
    chk("single_gnt",   32'(gnt),   32'h4);
    chk("single_din",   32'(din),   32'hA5);
    chk("single_owner", 32'(owner), 32'd2);
    req  = 4'b1011;
    data = 32'hFFFF_FFFF;
    tick();
    chk("single_wait_stt",   32'(stt),   32'd0);
    chk("single_wait_gnt",   32'(gnt),   32'd0);
    chk("single_wait_owner", 32'(owner), 32'd2);
    chk("single_wait_din",   32'(din),   32'hA5);
    repeat (17) tick();
    req = 4'b0000;
    chk("single_late_busy", 32'(busy), 32'd1);
    chk("single_late_din",  32'(din),  32'hA5);
    tick();
    eot = 1'b1;
    tick();
    eot = 1'b0;
    chk("single_end_busy",  32'(busy),  32'd0);
    chk("single_end_owner", 32'(owner), 32'd2);
    chk("single_end_din",   32'(din),   32'hA5);
    chk("single_end_err",   32'(err),   32'd0);

    // Stray eot while idle
    eot = 1'b1;
    tick();
    eot = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    tick();
    chk("stray_stt",   32'(stt),   32'd0);
    chk("stray_gnt",   32'(gnt),   32'd0);
    chk("stray_owner", 32'(owner), 32'd2);
    chk("stray_din",   32'(din),   32'hA5);

    // Skip / wrap
    data = 32'h4433_2211;
    req  = 4'b1000;
    transfer(3, 8'h44, 5, "wrap3");
    req  = 4'b0010;
    transfer(1, 8'h22, 5, "skip1");
    req  = 4'b1001;
    transfer(3, 8'h44, 5, "skip3");
    transfer(0, 8'h11, 5, "wrap0");
    req  = 4'b0000;

    // Watchdog abort on u_to (8-cycle watchdog)
    req_t  = 4'b1111;
    data_t = 32'hDDCC_BBAA;
    tick();
    $display("xfer to_a: owner=%0d byte=%02h gnt=%b", owner_t, din_t, gnt_t);
    chk("to_a_stt",   32'(stt_t),   32'd1);
    chk("to_a_gnt",   32'(gnt_t),   32'h1);
    chk("to_a_din",   32'(din_t),   32'hAA);
    repeat (8) tick();
    chk("to_a_pre_err",  32'(err_t),  32'd0);
    chk("to_a_pre_busy", 32'(busy_t), 32'd1);
    tick();
    chk("to_a_err",  32'(err_t),  32'd1);
    chk("to_a_busy", 32'(busy_t), 32'd0);
    tick();
    $display("xfer to_b: owner=%0d byte=%02h gnt=%b", owner_t, din_t, gnt_t);
    chk("to_a_err_once", 32'(err_t),   32'd0);
    chk("to_b_stt",      32'(stt_t),   32'd1);
    chk("to_b_gnt",      32'(gnt_t),   32'h2);
    chk("to_b_owner",    32'(owner_t), 32'd1);
    chk("to_b_din",      32'(din_t),   32'hBB);
    // eot arrives on the terminal-count cycle: no abort
    repeat (8) tick();
    eot_t = 1'b1;
    tick();
    eot_t = 1'b0;
    req_t = 4'b0000;
    chk("to_b_noerr", 32'(err_t),  32'd0);
    chk("to_b_idle",  32'(busy_t), 32'd0);
    tick();
    chk("to_b_noerr_late", 32'(err_t),  32'd0);
    chk("to_b_nostt",      32'(stt_t),  32'd0);

    // Reset in the middle of WAIT
    req  = 4'b0100;
    data = 32'h4433_2211;
    tick();
    chk("mid_owner", 32'(owner), 32'd2);
    req = 4'b0000;
    repeat (3) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_gnt",   32'(gnt),   32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_stt",   32'(stt),   32'd0);
    chk("mid_rst_din",   32'(din),   32'd0);
    chk("mid_rst_err",   32'(err),   32'd0);
    req = 4'b1111;
    tick();
    rst_n = 1'b1;
    transfer(0, 8'h11, 5, "post_rst");
    req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
